// File: rtl/vga_sprite_timing_gen.sv
// VGA raster generator with programmable timing/polarity and one bouncing sprite.
// Ports: pclk, rst_n (async, active-low), en, move_en, step[7:0],
//   fg_color/bg_color[3*COLOR_W-1:0], pattern_sel -> rgb, hsync, vsync, de,
//   frame_start, px_x/px_y[11:0]. All outputs registered (1-cycle latency).
// Optional feature: define VGA_TESTPAT_EN for the 8-bar colour test pattern.
module vga_sprite_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int COLOR_W   = 4,
    parameter int SPR_W     = 64,
    parameter int SPR_H     = 40,
    parameter int FRAME_DIV = 1
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 move_en,
    input  logic [7:0]           step,
    input  logic [3*COLOR_W-1:0] fg_color,
    input  logic [3*COLOR_W-1:0] bg_color,
    input  logic                 pattern_sel,
    output logic [3*COLOR_W-1:0] rgb,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic                 frame_start,
    output logic [11:0]          px_x,
    output logic [11:0]          px_y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [11:0] HT1 = 12'(H_TOTAL - 1);
    localparam logic [11:0] VT1 = 12'(V_TOTAL - 1);
    localparam logic [11:0] HA  = 12'(H_ACTIVE);
    localparam logic [11:0] VA  = 12'(V_ACTIVE);
    localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS0 = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] SW  = 12'(SPR_W);
    localparam logic [11:0] SH  = 12'(SPR_H);

    localparam logic signed [12:0] LX = 13'(H_ACTIVE - SPR_W);
    localparam logic signed [12:0] LY = 13'(V_ACTIVE - SPR_H);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    // raster counters
    logic [11:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic        hwrap, vwrap;

    // sprite state; dir bits are 1 when moving towards 0
    logic [11:0]      x_q, x_d, y_q, y_d;
    logic             dxn_q, dxn_d, dyn_q, dyn_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic signed [12:0] stp, nx, ny;

    // registered outputs
    logic [3*COLOR_W-1:0] rgb_q, rgb_d, img;
    logic                 hs_q, hs_d, vs_q, vs_d;
    logic                 de_q, de_d, fs_q, fs_d;
    logic [11:0]          px_q, px_d, py_q, py_d;
    logic                 act, hit;

    always_comb begin
        hwrap  = (hcnt_q == HT1);
        vwrap  = (vcnt_q == VT1);
        hcnt_d = 12'd0;
        vcnt_d = 12'd0;
        if (en) begin
            hcnt_d = hwrap ? 12'd0 : hcnt_q + 12'd1;
            vcnt_d = vcnt_q;
            if (hwrap)
                vcnt_d = vwrap ? 12'd0 : vcnt_q + 12'd1;
        end
    end

    // Motion happens on the last blanking pixel of the frame, so a frame
    // is always drawn with a single sprite position.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        dxn_d = dxn_q;
        dyn_d = dyn_q;
        div_d = div_q;
        stp   = $signed({5'b0, step});
        nx    = dxn_q ? $signed({1'b0, x_q}) - stp
                      : $signed({1'b0, x_q}) + stp;
        ny    = dyn_q ? $signed({1'b0, y_q}) - stp
                      : $signed({1'b0, y_q}) + stp;
        if (en && hwrap && vwrap) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (move_en) begin
                    if (nx >= LX) begin
                        x_d   = LX[11:0];
                        dxn_d = 1'b1;
                    end else if (nx <= 13'sd0) begin
                        x_d   = 12'd0;
                        dxn_d = 1'b0;
                    end else begin
                        x_d = nx[11:0];
                    end
                    if (ny >= LY) begin
                        y_d   = LY[11:0];
                        dyn_d = 1'b1;
                    end else if (ny <= 13'sd0) begin
                        y_d   = 12'd0;
                        dyn_d = 1'b0;
                    end else begin
                        y_d = ny[11:0];
                    end
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_comb begin
        act = (hcnt_q < HA) && (vcnt_q < VA);
        hit = (hcnt_q >= x_q) && (hcnt_q < x_q + SW) &&
              (vcnt_q >= y_q) && (vcnt_q < y_q + SH);
        img = hit ? fg_color : bg_color;
`ifdef VGA_TESTPAT_EN
        if (pattern_sel) begin
            logic [2:0] bar;
            bar = 3'((32'(hcnt_q) * 8) / H_ACTIVE);
            img = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}},
                   {COLOR_W{bar[0]}}};
        end
`endif
        rgb_d = '0;
        hs_d  = ~HS_POL;
        vs_d  = ~VS_POL;
        de_d  = 1'b0;
        fs_d  = 1'b0;
        px_d  = 12'd0;
        py_d  = 12'd0;
        if (en) begin
            rgb_d = act ? img : '0;
            hs_d  = (hcnt_q >= HS0 && hcnt_q < HS1) ? HS_POL : ~HS_POL;
            vs_d  = (vcnt_q >= VS0 && vcnt_q < VS1) ? VS_POL : ~VS_POL;
            de_d  = act;
            fs_d  = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
            px_d  = hcnt_q;
            py_d  = vcnt_q;
        end
    end

`ifndef VGA_TESTPAT_EN
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= 12'd0;
            vcnt_q <= 12'd0;
            x_q    <= 12'd0;
            y_q    <= 12'd0;
            dxn_q  <= 1'b0;
            dyn_q  <= 1'b0;
            div_q  <= '0;
            rgb_q  <= '0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= 1'b0;
            fs_q   <= 1'b0;
            px_q   <= 12'd0;
            py_q   <= 12'd0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            x_q    <= x_d;
            y_q    <= y_d;
            dxn_q  <= dxn_d;
            dyn_q  <= dyn_d;
            div_q  <= div_d;
            rgb_q  <= rgb_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            fs_q   <= fs_d;
            px_q   <= px_d;
            py_q   <= py_d;
        end
    end

    assign rgb         = rgb_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign px_x        = px_q;
    assign px_y        = py_q;

endmodule
